laplace_window_gen: RTL and testbench
=====================================

// Module: laplace_window_gen
// PURPOSE
//  Streaming window generator directly upstream of the approximate Laplace stage.
//  Accepts one 8-bit pixel per cycle in raster order and emits the 3x3 cross neighbourhood
//  (b=N, d=W, e=centre, f=E, h=S) for every interior pixel.
//  Two on-chip line buffers hold the previous two rows; border pixels produce no window.
//  Outputs b/d/e/f/h connect directly to the Laplace stage inputs of the same names.
// PARAMETERS
//  IMG_W  256  pixels per row (>=3)
//  IMG_H  256  rows per frame (>=3)
//  PIX_W  8    pixel width in bits
// PORTS
//  clk         in   1      single clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  pix_in      in   PIX_W  incoming pixel, raster order (row 0 col 0 first)
//  pix_valid   in   1      pix_in valid this cycle; no backpressure, every valid pixel is accepted
//  b,d,e,f,h   out  PIX_W  cross window: N, W, centre, E, S
//  win_valid   out  1      b..h hold a valid window this cycle
//  frame_done  out  1      one-cycle pulse coincident with the last window of a frame
// BEHAVIOUR
//  - clk only; rst synchronous, active-high.
//    On rst: col=0, row=0, win_valid=0, frame_done=0, b/d/e/f/h=0.
//    Line-buffer RAM is not cleared (rows 0-1 never produce windows).
//  - Counters: col counts 0..IMG_W-1 on each accepted pixel.
//    At IMG_W-1 col wraps to 0 and row increments.
//    At row=IMG_H-1, col=IMG_W-1, both wrap to 0; the next frame follows with no idle cycle.
//  - Line buffers L1 (row r-1) and L2 (row r-2), depth IMG_W, are read and written at address col.
//    On accept: L2[col]<=L1[col] and L1[col]<=pix_in.
//  - Tap registers shift only on accept. On accepting p(r,c), the window is centred at (r-1,c-1):
//    b=p(r-2,c-1), d=p(r-1,c-2), e=p(r-1,c-1), f=p(r-1,c), h=p(r,c-1).
//  - Window emitted iff r>=2 and c>=2. Yields (IMG_W-2)*(IMG_H-2) windows per frame.
//    Taps must not mix pixels across a row boundary.
//  - Latency: b..h and win_valid are registered. They are valid the cycle after the accepting edge (1 cycle).
//  - pix_valid=0: counters, buffers and taps hold. win_valid=0 and frame_done=0 that cycle.
//    b..h hold their last values.
//  - frame_done=1 with win_valid=1 for the window produced by p(IMG_H-1,IMG_W-1).
//  - rst mid-frame: the partial frame is discarded and no further windows from it are emitted.
//    The next accepted pixel is treated as p(0,0).
//  - rst has priority over pix_valid in the same cycle.
//  - Arithmetic: counters sized $clog2(IMG_W) / $clog2(IMG_H). No pixel arithmetic in this block.
// CONFIGURATION
//  LAPLACE_WIN_OUTREG_EN
//   Defined: adds a second output register stage on b..h, win_valid and frame_done.
//   Latency becomes 2 cycles, for timing closure ahead of the adder tree.
//   Reset clears both stages. Stall behaviour is unchanged.
//   A stalled cycle inserts win_valid=0 bubbles; window order is preserved.
//   Undefined: single output register, latency 1.
// TESTING (IMG_W=8, IMG_H=4 unless noted)
//  1. Constant frame, all pixels=100, pix_valid=1 continuously
//     -> exactly 12 win_valid pulses; b=d=e=f=h=100 on each; frame_done once, on pulse 12.
//  2. Ramp frame, pixel=row*8+col
//     -> first window b=1, d=8, e=9, f=10, h=17, exactly 1 cycle after accepting p(2,2)=18.
//     -> last window b=14, d=21, e=22, f=23, h=30.
//  3. Ramp frame with pix_valid alternating 1/0
//     -> identical window sequence to test 2; win_valid never high on the cycle after a pix_valid=0 cycle.
//  4. rst=1 for 1 cycle after p(2,4) accepted, then a full ramp frame
//     -> no window from the aborted frame after rst; output sequence identical to test 2.
//  5. Two back-to-back ramp frames, no gap
//     -> 24 windows; frame 2 first window b=1, d=8, e=9, f=10, h=17 (no cross-frame contamination);
//        frame_done pulses twice.
//  6. Test 2 rebuilt with LAPLACE_WIN_OUTREG_EN defined
//     -> same values; first win_valid 2 cycles after accepting p(2,2).

Source files
------------

// File: rtl/laplace_window_gen.sv
// laplace_window_gen: streaming 3x3 cross-window generator (N, W, centre, E, S)
// for interior pixels of a raster-order frame, feeding the approximate Laplace stage.
// Optional build macro: LAPLACE_WIN_OUTREG_EN adds a second output register stage
// (latency 2 instead of 1). With the macro undefined, a single output register is used.
module laplace_window_gen #(
    parameter int unsigned IMG_W = 256,
    parameter int unsigned IMG_H = 256,
    parameter int unsigned PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic [PIX_W-1:0] b,
    output logic [PIX_W-1:0] d,
    output logic [PIX_W-1:0] e,
    output logic [PIX_W-1:0] f,
    output logic [PIX_W-1:0] h,
    output logic             win_valid,
    output logic             frame_done
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    // Line buffers: l1 holds row r-1, l2 holds row r-2, both addressed by col
    logic [PIX_W-1:0] l1 [IMG_W];
    logic [PIX_W-1:0] l2 [IMG_W];

    logic [PIX_W-1:0] l1_rd_c;
    logic [PIX_W-1:0] l2_rd_c;
    logic             col_last_c;
    logic             row_last_c;
    logic             win_c;

    // Tap registers: previous column of the top, middle and bottom rows
    logic [PIX_W-1:0] top1;
    logic [PIX_W-1:0] mid1;
    logic [PIX_W-1:0] mid2;
    logic [PIX_W-1:0] bot1;

    // First output stage
    logic [PIX_W-1:0] b1, d1, e1, f1, h1;
    logic             win1;
    logic             fd1;

    // Read ports and position decode for the pixel being accepted
    always_comb begin
        l1_rd_c    = l1[col];
        l2_rd_c    = l2[col];
        col_last_c = (col == COL_W'(IMG_W - 1));
        row_last_c = (row == ROW_W'(IMG_H - 1));
        win_c      = pix_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
    end

    // Raster position counters; both wrap at the end of the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (pix_valid) begin
            if (col_last_c) begin
                col <= '0;
                row <= row_last_c ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Line buffer update; contents are never cleared since rows 0-1 emit nothing
    always_ff @(posedge clk) begin
        if (!rst && pix_valid) begin
            l2[col] <= l1_rd_c;
            l1[col] <= pix_in;
        end
    end

    // Tap shift registers advance only on an accepted pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            top1 <= '0;
            mid1 <= '0;
            mid2 <= '0;
            bot1 <= '0;
        end else if (pix_valid) begin
            top1 <= l2_rd_c;
            mid1 <= l1_rd_c;
            mid2 <= mid1;
            bot1 <= pix_in;
        end
    end

    // First output stage: capture the window centred at (row-1, col-1)
    always_ff @(posedge clk) begin
        if (rst) begin
            b1   <= '0;
            d1   <= '0;
            e1   <= '0;
            f1   <= '0;
            h1   <= '0;
            win1 <= 1'b0;
            fd1  <= 1'b0;
        end else begin
            win1 <= win_c;
            fd1  <= win_c && row_last_c && col_last_c;
            if (win_c) begin
                b1 <= top1;
                d1 <= mid2;
                e1 <= mid1;
                f1 <= l1_rd_c;
                h1 <= bot1;
            end
        end
    end

`ifdef LAPLACE_WIN_OUTREG_EN
    logic [PIX_W-1:0] b2, d2, e2, f2, h2;
    logic             win2;
    logic             fd2;

    // Second output stage for timing ahead of the adder tree
    always_ff @(posedge clk) begin
        if (rst) begin
            b2   <= '0;
            d2   <= '0;
            e2   <= '0;
            f2   <= '0;
            h2   <= '0;
            win2 <= 1'b0;
            fd2  <= 1'b0;
        end else begin
            b2   <= b1;
            d2   <= d1;
            e2   <= e1;
            f2   <= f1;
            h2   <= h1;
            win2 <= win1;
            fd2  <= fd1;
        end
    end

    assign b          = b2;
    assign d          = d2;
    assign e          = e2;
    assign f          = f2;
    assign h          = h2;
    assign win_valid  = win2;
    assign frame_done = fd2;
`else
    assign b          = b1;
    assign d          = d1;
    assign e          = e1;
    assign f          = f1;
    assign h          = h1;
    assign win_valid  = win1;
    assign frame_done = fd1;
`endif

endmodule

// File: tb/tb_laplace_window_gen.sv
// Bench for laplace_window_gen (IMG_W=8, IMG_H=4): directed frames plus randomized
// pixels/stalls/resets against a frame-image reference model.
module tb_laplace_window_gen;

    localparam int unsigned IMG_W = 8;
    localparam int unsigned IMG_H = 4;
    localparam int unsigned PIX_W = 8;
`ifdef LAPLACE_WIN_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic             v;
        logic             fd;
        logic [PIX_W-1:0] b, d, e, f, h;
    } win_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic [PIX_W-1:0] b, d, e, f, h;
    logic             win_valid;
    logic             frame_done;

    int n_vec  = 0;
    int n_miss = 0;
    int win_cnt = 0;
    int fd_cnt  = 0;

    // Reference model state: the frame image seen so far and the raster position
    int               mr = 0;
    int               mc = 0;
    logic [PIX_W-1:0] img [IMG_H][IMG_W];
    win_t             pipe [LAT];

    laplace_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
        .b(b), .d(d), .e(e), .f(f), .h(h),
        .win_valid(win_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model, then compare outputs after the edge
    task automatic step(input logic v, input logic [PIX_W-1:0] p, input logic r);
        win_t cur;
        cur = '{v: 1'b0, fd: 1'b0, b: '0, d: '0, e: '0, f: '0, h: '0};
        pix_valid = v;
        pix_in    = p;
        rst       = r;
        if (r) begin
            mr = 0;
            mc = 0;
            for (int i = 0; i < LAT; i++) pipe[i] = cur;
        end else begin
            if (v) begin
                img[mr][mc] = p;
                if (mr >= 2 && mc >= 2) begin
                    cur.v  = 1'b1;
                    cur.fd = (mr == IMG_H - 1) && (mc == IMG_W - 1);
                    cur.b  = img[mr-2][mc-1];
                    cur.d  = img[mr-1][mc-2];
                    cur.e  = img[mr-1][mc-1];
                    cur.f  = img[mr-1][mc];
                    cur.h  = img[mr][mc-1];
                end
                mc++;
                if (mc == IMG_W) begin
                    mc = 0;
                    mr = (mr == IMG_H - 1) ? 0 : mr + 1;
                end
            end
            for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = cur;
        end
        @(posedge clk);
        #1;
        chk("win_valid", int'(win_valid), int'(pipe[LAT-1].v));
        chk("frame_done", int'(frame_done), int'(pipe[LAT-1].fd));
        if (pipe[LAT-1].v) begin
            chk("b", int'(b), int'(pipe[LAT-1].b));
            chk("d", int'(d), int'(pipe[LAT-1].d));
            chk("e", int'(e), int'(pipe[LAT-1].e));
            chk("f", int'(f), int'(pipe[LAT-1].f));
            chk("h", int'(h), int'(pipe[LAT-1].h));
        end
        if (win_valid)  win_cnt++;
        if (frame_done) fd_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic ramp_frame(input bit alternate);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                step(1'b1, PIX_W'(r * IMG_W + c), 1'b0);
                if (alternate) step(1'b0, 8'hAA, 1'b0);
            end
    endtask

    initial begin
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_in = '0;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        chk("rst_b", int'(b), 0);
        chk("rst_d", int'(d), 0);
        chk("rst_e", int'(e), 0);
        chk("rst_f", int'(f), 0);
        chk("rst_h", int'(h), 0);

        // Constant frame
        win_cnt = 0; fd_cnt = 0;
        for (int i = 0; i < IMG_W * IMG_H; i++) step(1'b1, 8'd100, 1'b0);
        idle(LAT + 1);
        chk("const_windows", win_cnt, 12);
        chk("const_frame_done", fd_cnt, 1);

        // Ramp frame, continuous
        win_cnt = 0; fd_cnt = 0;
        ramp_frame(1'b0);
        idle(LAT + 1);
        chk("ramp_windows", win_cnt, 12);
        chk("ramp_frame_done", fd_cnt, 1);

        // Ramp frame with alternating stalls
        win_cnt = 0; fd_cnt = 0;
        ramp_frame(1'b1);
        idle(LAT + 1);
        chk("alt_windows", win_cnt, 12);

        // Abort after p(2,4), then a clean ramp frame
        for (int i = 0; i < 2 * IMG_W + 5; i++) step(1'b1, PIX_W'(i), 1'b0);
        step(1'b0, '0, 1'b1);
        win_cnt = 0; fd_cnt = 0;
        ramp_frame(1'b0);
        idle(LAT + 1);
        chk("abort_windows", win_cnt, 12);

        // Two back-to-back ramp frames
        win_cnt = 0; fd_cnt = 0;
        ramp_frame(1'b0);
        ramp_frame(1'b0);
        idle(LAT + 1);
        chk("b2b_windows", win_cnt, 24);
        chk("b2b_frame_done", fd_cnt, 2);

        // Random pixels with random stalls and occasional resets
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, PIX_W'($urandom_range(0, 255)),
                 $urandom_range(0, 499) == 0);
        end
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
